// File: rtl/core161c_ctl.sv
// Type 161C core memory emulation: four-port PDP-10 membus front end over a 36-bit Avalon-MM word store.
// Optional single-step mode is built when CORE161C_SINGLE_STEP_EN is defined.
// DEC bit k of a field numbered [a:35] lives at index 35-k (ma[35] is bit 0, mb[0] is bit 35).
module core161c_ctl #(
  parameter logic [3:0] memsel_p0 = 4'b0000,
  parameter logic [3:0] memsel_p1 = 4'b0000,
  parameter logic [3:0] memsel_p2 = 4'b0000,
  parameter logic [3:0] memsel_p3 = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power,
  input  logic        sw_single_step,
  input  logic        sw_restart,

  input  logic        membus_rq_cyc_p0,
  input  logic        membus_rd_rq_p0,
  input  logic        membus_wr_rq_p0,
  input  logic        membus_wr_rs_p0,
  input  logic [3:0]  membus_sel_p0,
  input  logic        membus_fmc_select_p0,
  input  logic [14:0] membus_ma_p0,
  input  logic [35:0] membus_mb_in_p0,
  output logic        membus_addr_ack_p0,
  output logic        membus_rd_rs_p0,
  output logic [35:0] membus_mb_out_p0,

  input  logic        membus_rq_cyc_p1,
  input  logic        membus_rd_rq_p1,
  input  logic        membus_wr_rq_p1,
  input  logic        membus_wr_rs_p1,
  input  logic [3:0]  membus_sel_p1,
  input  logic        membus_fmc_select_p1,
  input  logic [14:0] membus_ma_p1,
  input  logic [35:0] membus_mb_in_p1,
  output logic        membus_addr_ack_p1,
  output logic        membus_rd_rs_p1,
  output logic [35:0] membus_mb_out_p1,

  input  logic        membus_rq_cyc_p2,
  input  logic        membus_rd_rq_p2,
  input  logic        membus_wr_rq_p2,
  input  logic        membus_wr_rs_p2,
  input  logic [3:0]  membus_sel_p2,
  input  logic        membus_fmc_select_p2,
  input  logic [14:0] membus_ma_p2,
  input  logic [35:0] membus_mb_in_p2,
  output logic        membus_addr_ack_p2,
  output logic        membus_rd_rs_p2,
  output logic [35:0] membus_mb_out_p2,

  input  logic        membus_rq_cyc_p3,
  input  logic        membus_rd_rq_p3,
  input  logic        membus_wr_rq_p3,
  input  logic        membus_wr_rs_p3,
  input  logic [3:0]  membus_sel_p3,
  input  logic        membus_fmc_select_p3,
  input  logic [14:0] membus_ma_p3,
  input  logic [35:0] membus_mb_in_p3,
  output logic        membus_addr_ack_p3,
  output logic        membus_rd_rs_p3,
  output logic [35:0] membus_mb_out_p3,

  output logic [17:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [35:0] m_writedata,
  input  logic [35:0] m_readdata,
  input  logic        m_waitrequest
);

  localparam int unsigned NP  = 4;
  localparam int unsigned AW  = 14;
  localparam int unsigned MAW = 18;
  localparam int unsigned DW  = 36;

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_RD, S_RS, S_WWAIT, S_WR, S_STEP
  } state_t;

  state_t        state;
  logic [1:0]    port_q;
  logic [AW-1:0] addr_q;
  logic          rd_q;
  logic          wr_q;
  logic [DW-1:0] data_q;
  logic [NP-1:0] lock_q;
  logic [NP-1:0] addr_ack_q;
  logic [NP-1:0] rd_rs_q;
  logic [DW-1:0] mb_out_q [NP];

  // Per-port views of the membus inputs
  logic [NP-1:0] rq_cyc, rd_rq, wr_rq, wr_rs, fmc;
  logic [3:0]    sel    [NP];
  logic [3:0]    memsel [NP];
  logic [AW-1:0] ma     [NP];
  logic [DW-1:0] mb_in  [NP];

  assign rq_cyc = {membus_rq_cyc_p3, membus_rq_cyc_p2, membus_rq_cyc_p1, membus_rq_cyc_p0};
  assign rd_rq  = {membus_rd_rq_p3, membus_rd_rq_p2, membus_rd_rq_p1, membus_rd_rq_p0};
  assign wr_rq  = {membus_wr_rq_p3, membus_wr_rq_p2, membus_wr_rq_p1, membus_wr_rq_p0};
  assign wr_rs  = {membus_wr_rs_p3, membus_wr_rs_p2, membus_wr_rs_p1, membus_wr_rs_p0};
  assign fmc    = {membus_fmc_select_p3, membus_fmc_select_p2,
                   membus_fmc_select_p1, membus_fmc_select_p0};

  assign sel[0] = membus_sel_p0;
  assign sel[1] = membus_sel_p1;
  assign sel[2] = membus_sel_p2;
  assign sel[3] = membus_sel_p3;

  assign memsel[0] = memsel_p0;
  assign memsel[1] = memsel_p1;
  assign memsel[2] = memsel_p2;
  assign memsel[3] = memsel_p3;

  // Top address bit (DEC ma[21]) is dropped: 16K words wrap
  assign ma[0] = membus_ma_p0[AW-1:0];
  assign ma[1] = membus_ma_p1[AW-1:0];
  assign ma[2] = membus_ma_p2[AW-1:0];
  assign ma[3] = membus_ma_p3[AW-1:0];

  assign mb_in[0] = membus_mb_in_p0;
  assign mb_in[1] = membus_mb_in_p1;
  assign mb_in[2] = membus_mb_in_p2;
  assign mb_in[3] = membus_mb_in_p3;

  assign membus_addr_ack_p0 = addr_ack_q[0];
  assign membus_addr_ack_p1 = addr_ack_q[1];
  assign membus_addr_ack_p2 = addr_ack_q[2];
  assign membus_addr_ack_p3 = addr_ack_q[3];
  assign membus_rd_rs_p0    = rd_rs_q[0];
  assign membus_rd_rs_p1    = rd_rs_q[1];
  assign membus_rd_rs_p2    = rd_rs_q[2];
  assign membus_rd_rs_p3    = rd_rs_q[3];
  assign membus_mb_out_p0   = mb_out_q[0];
  assign membus_mb_out_p1   = mb_out_q[1];
  assign membus_mb_out_p2   = mb_out_q[2];
  assign membus_mb_out_p3   = mb_out_q[3];

  logic          unused_ok;
  logic          step_go;
  logic          restart_rise;

`ifdef CORE161C_SINGLE_STEP_EN
  logic restart_q;

  // Synchronous edge detect of the continue switch
  always_ff @(posedge clk) begin
    if (!reset || !power) restart_q <= 1'b0;
    else                  restart_q <= sw_restart;
  end

  assign step_go      = sw_single_step;
  assign restart_rise = sw_restart & ~restart_q;
  assign unused_ok    = &{1'b0, membus_ma_p0[AW], membus_ma_p1[AW],
                          membus_ma_p2[AW], membus_ma_p3[AW]};
`else
  assign step_go      = 1'b0;
  assign restart_rise = 1'b1;
  assign unused_ok    = &{1'b0, membus_ma_p0[AW], membus_ma_p1[AW],
                          membus_ma_p2[AW], membus_ma_p3[AW],
                          sw_single_step, sw_restart};
`endif

  // Eligibility and fixed priority, p0 highest
  logic [NP-1:0] elig;
  logic [1:0]    gnt;

  always_comb begin
    elig = '0;
    gnt  = 2'd0;
    for (int i = 0; i < NP; i++) begin
      elig[i] = rq_cyc[i] && (sel[i] == memsel[i]) && !fmc[i] && !lock_q[i];
    end
    for (int i = NP - 1; i >= 0; i--) begin
      if (elig[i]) gnt = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !power) begin
      state       <= S_IDLE;
      port_q      <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      lock_q      <= '0;
      addr_ack_q  <= '0;
      rd_rs_q     <= '0;
      m_address   <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= '0;
      for (int i = 0; i < NP; i++) mb_out_q[i] <= '0;
    end else begin
      addr_ack_q <= '0;
      rd_rs_q    <= '0;
      for (int i = 0; i < NP; i++) mb_out_q[i] <= '0;
      // A lock stays only while its port keeps rq_cyc asserted
      lock_q <= lock_q & rq_cyc;

      case (state)
        S_IDLE: begin
          if (|elig) begin
            port_q <= gnt;
            addr_q <= ma[gnt];
            rd_q   <= rd_rq[gnt];
            wr_q   <= wr_rq[gnt];
            state  <= S_ACK;
          end
        end
        S_ACK: begin
          addr_ack_q[port_q] <= 1'b1;
          lock_q[port_q]     <= rq_cyc[port_q];
          if (rd_q) begin
            m_read    <= 1'b1;
            m_address <= MAW'(addr_q);
            state     <= S_RD;
          end else if (wr_q) begin
            state <= S_WWAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RD: begin
          if (!m_waitrequest) begin
            m_read <= 1'b0;
            data_q <= m_readdata;
            state  <= S_RS;
          end
        end
        S_RS: begin
          rd_rs_q[port_q]  <= 1'b1;
          mb_out_q[port_q] <= data_q;
          if (wr_q)         state <= S_WWAIT;
          else if (step_go) state <= S_STEP;
          else              state <= S_IDLE;
        end
        S_WWAIT: begin
          if (wr_rs[port_q]) begin
            m_write     <= 1'b1;
            m_address   <= MAW'(addr_q);
            m_writedata <= mb_in[port_q];
            state       <= S_WR;
          end
        end
        S_WR: begin
          if (!m_waitrequest) begin
            m_write <= 1'b0;
            state   <= step_go ? S_STEP : S_IDLE;
          end
        end
        S_STEP: begin
          if (restart_rise) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core161c_ctl.sv
// Scoreboard bench for core161c_ctl: Avalon RAM model, expected acks/reads/writes queued at stimulus time.
module tb_core161c_ctl;

  typedef struct packed {
    logic [1:0]  port;
    logic [35:0] data;
  } rd_exp_t;

  typedef struct packed {
    logic [17:0] addr;
    logic [35:0] data;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        reset, power, sw_single_step, sw_restart;
  logic [3:0]  rq_cyc, rd_rq, wr_rq, wr_rs, fmc;
  logic [3:0]  sel   [4];
  logic [14:0] ma    [4];
  logic [35:0] mb_in [4];
  logic [3:0]  addr_ack, rd_rs;
  logic [35:0] mb_out [4];
  logic [17:0] m_address;
  logic        m_read, m_write, m_waitrequest;
  logic [35:0] m_writedata, m_readdata;

  logic [35:0] ram    [16384];
  logic [35:0] shadow [16384];
  int wait_cfg = 0;
  int wcnt = 0;
  int cyc = 0;

  int vectors = 0;
  int miscompares = 0;

  int ack_cnt [4];
  int rs_cnt  [4];
  int ack_cyc [4];
  int rs_cyc  [4];
  int writes_done = 0;
  int mwrite_seen = 0;
  int mwr_cyc = 0;
  int rd_len_cur = 0;
  int rd_len_last = 0;
  logic m_write_prev = 1'b0;

  rd_exp_t exp_rd  [$];
  wr_exp_t exp_wr  [$];
  logic [1:0] exp_ack [$];

  always #5 clk = ~clk;

  core161c_ctl dut (
    .clk(clk), .reset(reset), .power(power),
    .sw_single_step(sw_single_step), .sw_restart(sw_restart),
    .membus_rq_cyc_p0(rq_cyc[0]), .membus_rd_rq_p0(rd_rq[0]), .membus_wr_rq_p0(wr_rq[0]),
    .membus_wr_rs_p0(wr_rs[0]), .membus_sel_p0(sel[0]), .membus_fmc_select_p0(fmc[0]),
    .membus_ma_p0(ma[0]), .membus_mb_in_p0(mb_in[0]), .membus_addr_ack_p0(addr_ack[0]),
    .membus_rd_rs_p0(rd_rs[0]), .membus_mb_out_p0(mb_out[0]),
    .membus_rq_cyc_p1(rq_cyc[1]), .membus_rd_rq_p1(rd_rq[1]), .membus_wr_rq_p1(wr_rq[1]),
    .membus_wr_rs_p1(wr_rs[1]), .membus_sel_p1(sel[1]), .membus_fmc_select_p1(fmc[1]),
    .membus_ma_p1(ma[1]), .membus_mb_in_p1(mb_in[1]), .membus_addr_ack_p1(addr_ack[1]),
    .membus_rd_rs_p1(rd_rs[1]), .membus_mb_out_p1(mb_out[1]),
    .membus_rq_cyc_p2(rq_cyc[2]), .membus_rd_rq_p2(rd_rq[2]), .membus_wr_rq_p2(wr_rq[2]),
    .membus_wr_rs_p2(wr_rs[2]), .membus_sel_p2(sel[2]), .membus_fmc_select_p2(fmc[2]),
    .membus_ma_p2(ma[2]), .membus_mb_in_p2(mb_in[2]), .membus_addr_ack_p2(addr_ack[2]),
    .membus_rd_rs_p2(rd_rs[2]), .membus_mb_out_p2(mb_out[2]),
    .membus_rq_cyc_p3(rq_cyc[3]), .membus_rd_rq_p3(rd_rq[3]), .membus_wr_rq_p3(wr_rq[3]),
    .membus_wr_rs_p3(wr_rs[3]), .membus_sel_p3(sel[3]), .membus_fmc_select_p3(fmc[3]),
    .membus_ma_p3(ma[3]), .membus_mb_in_p3(mb_in[3]), .membus_addr_ack_p3(addr_ack[3]),
    .membus_rd_rs_p3(rd_rs[3]), .membus_mb_out_p3(mb_out[3]),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
  );

  // Avalon word store with a programmable number of wait states per access
  assign m_waitrequest = (m_read || m_write) && (wcnt < wait_cfg);
  assign m_readdata    = ram[m_address[13:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_read || m_write) wcnt <= m_waitrequest ? wcnt + 1 : 0;
    if (m_write && !m_waitrequest) ram[m_address[13:0]] <= m_writedata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every DUT response
  initial begin
    rd_exp_t r;
    wr_exp_t w;
    logic [1:0] pa;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (addr_ack[i]) begin
          ack_cnt[i]++;
          ack_cyc[i] = cyc;
          if (exp_ack.size() == 0) chk("ack_unexpected", 64'(i), 64'hff);
          else begin
            pa = exp_ack.pop_front();
            chk("ack_port", 64'(i), 64'(pa));
          end
        end
        if (rd_rs[i]) begin
          rs_cnt[i]++;
          rs_cyc[i] = cyc;
          if (exp_rd.size() == 0) chk("rs_unexpected", 64'(i), 64'hff);
          else begin
            r = exp_rd.pop_front();
            chk("rs_port", 64'(i), 64'(r.port));
            chk("rs_data", 64'(mb_out[i]), 64'(r.data));
          end
        end else begin
          chk("mb_out_idle", 64'(mb_out[i]), 64'd0);
        end
      end
      if (m_read) rd_len_cur++;
      else if (rd_len_cur != 0) begin
        rd_len_last = rd_len_cur;
        rd_len_cur  = 0;
      end
      if (m_write) mwrite_seen++;
      if (m_write && !m_write_prev) mwr_cyc = cyc;
      m_write_prev = m_write;
      if (m_write && !m_waitrequest) begin
        writes_done++;
        if (exp_wr.size() == 0) chk("wr_unexpected", 64'(m_address), 64'hffff_ffff);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 64'(m_address), 64'(w.addr));
          chk("wr_data", 64'(m_writedata), 64'(w.data));
        end
      end
    end
  end

  function automatic int cnt_of(input int kind, input int p);
    case (kind)
      0:       return ack_cnt[p];
      1:       return rs_cnt[p];
      default: return writes_done;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int kind, input int p, input int target);
    int n = 0;
    while (cnt_of(kind, p) < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(cnt_of(kind, p) >= target), 64'd1);
  endtask

  task automatic start_rq(input int p, input logic [14:0] a, input logic rd, input logic wr);
    rd_exp_t e;
    ma[p] = a; rd_rq[p] = rd; wr_rq[p] = wr; rq_cyc[p] = 1'b1;
    exp_ack.push_back(2'(p));
    if (rd) begin
      e.port = 2'(p);
      e.data = shadow[a[13:0]];
      exp_rd.push_back(e);
    end
  endtask

  task automatic drop_rq(input int p);
    rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0; wr_rq[p] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read(input int p, input logic [14:0] a, input bit drop);
    int c0 = cyc;
    int a0 = ack_cnt[p];
    int r0 = rs_cnt[p];
    start_rq(p, a, 1'b1, 1'b0);
    wait_until("ack_timeout", 0, p, a0 + 1);
    chk("ack_latency", 64'(ack_cyc[p] - c0), 64'd2);
    wait_until("rs_timeout", 1, p, r0 + 1);
    chk("rs_latency", 64'(rs_cyc[p] - ack_cyc[p]), 64'(2 + wait_cfg));
    if (drop) drop_rq(p);
  endtask

  task automatic do_write(input int p, input logic [14:0] a, input logic [35:0] d, input logic rd);
    wr_exp_t w;
    int a0 = ack_cnt[p];
    int r0 = rs_cnt[p];
    int w0 = writes_done;
    int wc0;
    start_rq(p, a, rd, 1'b1);
    wait_until("wack_timeout", 0, p, a0 + 1);
    if (rd) wait_until("wrs_timeout", 1, p, r0 + 1);
    @(negedge clk);
    wr_rs[p] = 1'b1; mb_in[p] = d; wc0 = cyc;
    w.addr = 18'(a[13:0]);
    w.data = d;
    exp_wr.push_back(w);
    shadow[a[13:0]] = d;
    @(negedge clk);
    wr_rs[p] = 1'b0;
    wait_until("wr_timeout", 2, p, w0 + 1);
    chk("wr_latency", 64'(mwr_cyc - wc0), 64'd1);
    drop_rq(p);
  endtask

  initial begin
    int a0, w0, s0;
    reset = 1'b0; power = 1'b1; sw_single_step = 1'b0; sw_restart = 1'b0;
    rq_cyc = '0; rd_rq = '0; wr_rq = '0; wr_rs = '0; fmc = '0;
    for (int i = 0; i < 4; i++) begin
      sel[i] = 4'd0; ma[i] = '0; mb_in[i] = '0;
      ack_cnt[i] = 0; rs_cnt[i] = 0; ack_cyc[i] = 0; rs_cyc[i] = 0;
    end
    for (int i = 0; i < 16384; i++) begin
      ram[i]    = 36'(i * 36'o1001 + 36'o7);
      shadow[i] = ram[i];
    end
    ram[16]    = 36'o201040001234;
    shadow[16] = 36'o201040001234;

    repeat (3) @(negedge clk);
    chk("rst_m_read", 64'(m_read), 64'd0);
    chk("rst_m_write", 64'(m_write), 64'd0);
    chk("rst_m_address", 64'(m_address), 64'd0);
    chk("rst_m_writedata", 64'(m_writedata), 64'd0);
    chk("rst_addr_ack", 64'(addr_ack), 64'd0);
    chk("rst_rd_rs", 64'(rd_rs), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Plain read, then write + readback, then RMW
    s0 = mwrite_seen;
    do_read(0, 15'o20, 1'b1);
    chk("read_no_write", 64'(mwrite_seen), 64'(s0));
    do_write(0, 15'o3, 36'o777777777777, 1'b0);
    do_read(0, 15'o3, 1'b1);
    do_write(0, 15'o5, 36'o1234, 1'b1);
    do_read(0, 15'o5, 1'b1);

    // ma[21] ignored: 0o40020 aliases 0o20; port 3 path
    do_read(3, 15'o40020, 1'b1);

    // fmc_select and select-code mismatch are both ignored
    a0 = ack_cnt[0];
    fmc[0] = 1'b1; rq_cyc[0] = 1'b1; rd_rq[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("fmc_no_ack", 64'(ack_cnt[0]), 64'(a0));
    fmc[0] = 1'b0; sel[0] = 4'd1;
    repeat (10) @(negedge clk);
    chk("sel_no_ack", 64'(ack_cnt[0]), 64'(a0));
    sel[0] = 4'd0;
    drop_rq(0);

    // Simultaneous p0 and p2: p0 first
    start_rq(0, 15'o20, 1'b1, 1'b0);
    start_rq(2, 15'o3, 1'b1, 1'b0);
    a0 = ack_cnt[2];
    wait_until("prio_timeout", 1, 2, rs_cnt[2] + 1);
    chk("prio_order", 64'(ack_cyc[2] > rs_cyc[0]), 64'd1);
    chk("prio_p2_once", 64'(ack_cnt[2]), 64'(a0 + 1));
    rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0;
    drop_rq(2);

    // Held rq_cyc gives exactly one cycle until it is dropped
    a0 = ack_cnt[1];
    do_read(1, 15'o7, 1'b0);
    repeat (12) @(negedge clk);
    chk("held_one_ack", 64'(ack_cnt[1]), 64'(a0 + 1));
    drop_rq(1);
    do_read(1, 15'o7, 1'b1);
    chk("held_second_ack", 64'(ack_cnt[1]), 64'(a0 + 2));

    // Five wait states stretch m_read to six clocks
    wait_cfg = 5;
    do_read(0, 15'o20, 1'b1);
    chk("wait_read_len", 64'(rd_len_last), 64'd6);
    wait_cfg = 0;

    // Reset during WWAIT abandons the write
    w0 = writes_done; s0 = mwrite_seen;
    start_rq(0, 15'o11, 1'b0, 1'b1);
    wait_until("rw_ack_timeout", 0, 0, ack_cnt[0] + 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rq_cyc[0] = 1'b0; wr_rq[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rw_m_write", 64'(m_write), 64'd0);
    chk("rw_m_address", 64'(m_address), 64'd0);
    chk("rw_addr_ack", 64'(addr_ack), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    wr_rs[0] = 1'b1; mb_in[0] = 36'o525252525252;
    @(negedge clk);
    wr_rs[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("rw_no_write", 64'(writes_done), 64'(w0));
    chk("rw_no_m_write", 64'(mwrite_seen), 64'(s0));
    do_read(0, 15'o11, 1'b1);

    repeat (4) @(negedge clk);
    chk("ackq_empty", 64'(exp_ack.size()), 64'd0);
    chk("rdq_empty", 64'(exp_rd.size()), 64'd0);
    chk("wrq_empty", 64'(exp_wr.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core161c_ctl.md
# core161c_ctl

Memory controller emulating a DEC Type 161C 16K-word core memory on the PDP-10 memory bus. It accepts requests from up to four processor ports, arbitrates them, and performs each read, write or read-modify-write cycle against an external 36-bit Avalon-MM word store. It sits between the KA10 processor's membus port(s) and the backing RAM.

## Interface
- `memsel_p0`..`memsel_p3`, default 4'b0000: memory select code that port n answers to; compared against that port's `membus_sel_pn`.
- `clk` in 1: single system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low.
- `power` in 1: power switch; low holds the block idle, like reset.
- `sw_single_step` in 1: single-step mode (see Configuration).
- `sw_restart` in 1: continue pulse for single-step (see Configuration).
- Ports n=0..3 each have the following signals:
  - `membus_rq_cyc_pn` in 1: request cycle.
  - `membus_rd_rq_pn` in 1: read request.
  - `membus_wr_rq_pn` in 1: write request.
  - `membus_wr_rs_pn` in 1: write restart; write data valid.
  - `membus_sel_pn` in [18:21]: memory select.
  - `membus_fmc_select_pn` in 1: fast memory (ACs) selected; core must ignore the request.
  - `membus_ma_pn` in [21:35]: word address.
  - `membus_mb_in_pn` in [0:35]: write data; bit 0 is the MSB.
  - `membus_addr_ack_pn` out 1: address acknowledge pulse.
  - `membus_rd_rs_pn` out 1: read restart pulse.
  - `membus_mb_out_pn` out [0:35]: read data. It is 0 whenever not driving.
- `m_address` out [17:0]: Avalon word address.
- `m_read` out 1: Avalon read strobe.
- `m_write` out 1: Avalon write strobe.
- `m_writedata` out [35:0]: Avalon write data.
- `m_readdata` in [35:0]: Avalon read data.
- `m_waitrequest` in 1: Avalon wait request.

## Operation
- **Port eligibility.** Port n is eligible when all of the following hold:
  - `rq_cyc_pn`=1.
  - `sel_pn`==`memsel_pn`.
  - `fmc_select_pn`=0.
  - Port not locked.
  - Priority on simultaneous requests: p0 > p1 > p2 > p3.
- **States.** IDLE, ACK, RD, RS, WWAIT, WR, STEP.
- **IDLE.**
  - When an eligible port exists, latch the port number, `ma[22:35]`, `rd_rq` and `wr_rq`, then go to ACK.
  - `ma[21]` is ignored; addresses wrap modulo 16K.
- **ACK.**
  - Pulse `addr_ack` of the latched port for 1 clk and set that port's lock.
  - Go to RD if `rd_rq`, else WWAIT.
  - A request with neither `rd_rq` nor `wr_rq` acks and returns to IDLE.
- **RD.**
  - Hold `m_read`=1 with `m_address`={4'b0, ma[22:35]} until `m_waitrequest`=0.
  - Capture `m_readdata` on that cycle, then go to RS.
- **RS.**
  - Pulse `rd_rs` for 1 clk with `mb_out` = captured data, mapping `mb_out[0]`=`data[35]` … `mb_out[35]`=`data[0]`.
  - Go to WWAIT if `wr_rq` (read-modify-write), else finish.
- **WWAIT.** Wait, indefinitely, for `wr_rs` of the latched port. Latch `mb_in` on that cycle, then go to WR.
- **WR.** Hold `m_write`=1 with the latched address and data until `m_waitrequest`=0, then finish.
- **Finish.** Go to STEP if single-step is active, else IDLE.
- **Port lock.** Cleared when that port's `rq_cyc` is sampled low. This prevents a held `rq_cyc` from starting a second cycle.
- **Power/reset.** `power`=0 or `reset`=0 forces IDLE, clears all locks, and zeroes all outputs. Applied mid-cycle, the cycle is abandoned with no Avalon write issued.
- Signals from non-latched ports are ignored during a cycle.

## Timing
- Reset value of every output is 0.
- `addr_ack` rises 2 clks after `rq_cyc` is first sampled (IDLE→ACK register, then ACK output).
- Read with zero wait states: `rd_rs` rises 2 clks after `addr_ack`.
- `mb_out` is non-zero only during the `rd_rs` cycle.
- Write: `m_write` rises 1 clk after `wr_rs` is sampled.
- Earliest next cycle: 1 clk after returning to IDLE.

## Configuration
- `CORE161C_SINGLE_STEP_EN` defined:
  - With `sw_single_step`=1, each completed cycle enters STEP.
  - STEP leaves to IDLE on the rising edge of `sw_restart`, detected synchronously.
- `CORE161C_SINGLE_STEP_EN` undefined:
  - `sw_single_step` and `sw_restart` are ignored.
  - STEP is never entered.

## Test plan
- Read: RAM[0o20]=0o201040001234; p0 rq_cyc+rd_rq, ma=0o20, sel=0 → `addr_ack_p0` pulse, then `rd_rs_p0` with `mb_out_p0`=0o201040001234; no `m_write`.
- Write: p0 wr_rq, ma=3, then wr_rs with mb_in=0o777777777777 → `m_write` at `m_address`=3 with data 0o777777777777; subsequent read of 3 returns it.
- RMW: rd_rq+wr_rq at address 5 → `rd_rs` with old data; then `wr_rs` with mb_in=0o1234 → RAM[5]=0o1234.
- Filtering/priority:
  - `fmc_select_p0`=1 → no ack.
  - `sel_p0`=1 with `memsel_p0`=0 → no ack.
  - p0 and p2 requesting on the same cycle → p0 served first, p2 next.
- Held `rq_cyc`: keep rq_cyc=1 after the read completes → exactly one ack. Drop rq_cyc, then raise it again → second ack.
- Wait states/reset: `m_waitrequest`=1 for 5 clks → `m_read` held 6 clks, `rd_rs` delayed accordingly. `reset`=0 while in WWAIT → IDLE, outputs 0, no `m_write`.
